piano_key_ctrl: RTL and testbench
=================================

# piano_key_ctrl

Front end of the piano keyboard display path: synchronises and debounces the three active-low note keys (do, re, mi). It converts each debounced press or release into a one-key draw command for the downstream square-drawing datapath. Commands are issued one at a time over a valid/ready handshake, with round-robin fairness across keys. Debounced key levels are also exported for the tone stage.

## Interface
- DEBOUNCE_CYCLES, 500000, stable-input cycles required to accept a level change (10 ms at 50 MHz); legal range 2..2^CNT_W-1
- CNT_W, 19, debounce counter width
- clk  in  1  system clock, 50 MHz
- resetn  in  1  synchronous, active-low reset
- key_n  in  3  raw asynchronous keys, 0 = pressed; bit 0 do, bit 1 re, bit 2 mi
- draw_ready  in  1  downstream idle and able to accept a command
- draw_valid  out  1  command valid
- draw_key  out  2  key index 0..2 of the command
- draw_on  out  1  1 = draw key lit, 0 = draw key dark
- key_down  out  3  debounced levels, 1 = held

## Operation
- **Synchroniser:** two flops per key; reset value 1 (released).
- **Debounce, per key:**
  - State: stable level `st` (reset 1) and counter `cnt` (reset 0).
  - If synced input equals `st`: cnt <= 0.
  - Otherwise, if cnt == DEBOUNCE_CYCLES-1: `st` flips, cnt <= 0, and a one-cycle `chg` pulse is raised.
  - Otherwise: cnt increments.
  - A glitch shorter than DEBOUNCE_CYCLES never changes `st`.
- **key_down[k]** = ~st[k].
- **Pending registers, per key:** `pend[k]` and `pend_on[k]`.
  - A `chg` pulse sets pend[k] <= 1 and pend_on[k] <= ~st_new.
  - A later change before issue overwrites pend_on (latest level wins); there is no queue depth beyond one per key.
- **FSM states:** IDLE, ISSUE.
  - **IDLE:** if any pend bit is set, select the first set key scanning from `ptr` upward, mod 3.
    - Load draw_key and draw_on.
    - Clear pend[sel].
    - Go to ISSUE.
    - If `chg` for the selected key arrives in the same cycle, the set wins: pend stays 1 with the new pend_on.
  - **ISSUE:** draw_valid = 1; draw_key and draw_on are held stable.
    - When draw_ready = 1: the handshake completes, ptr <= (sel+1) mod 3, and the FSM returns to IDLE.
    - Otherwise the FSM stays in ISSUE.
- **ptr:** 2-bit, values 0..2, reset 0; the value 3 is unreachable.
- **Reset mid-operation:** all state is cleared, any pending commands are dropped, draw_valid drops in the next cycle. After reset all keys read as released, so no commands are issued until a key is pressed.

## Timing
- **Reset values:** draw_valid 0, draw_key 0, draw_on 0, key_down 000, ptr 0, all pend 0.
- **Key-to-key_down latency:** key_n change to key_down change = 2 (sync) + DEBOUNCE_CYCLES cycles.
- **chg-to-draw_valid latency:** draw_valid rises 1 cycle after the `chg` pulse when the FSM is in IDLE. Worst case while busy: issue waits for the current handshake plus up to two earlier keys.
- **Throughput:** at most one command per 2 cycles (ISSUE → IDLE → ISSUE).
- draw_valid must not drop and the command must not change until the handshake completes.
- All outputs are registered.

## Structure
- **Package `piano_pkg`:**
  - NUM_KEYS = 3
  - KEY_DO = 0, KEY_RE = 1, KEY_MI = 2
  - State enum for IDLE/ISSUE
  - Per-key lit colours: do 3'b100, re 3'b010, mi 3'b001; dark 3'b000
  - Per-key square x origins: 0, 64, 128; shared y origin 87
  - These constants are shared with the drawing datapath.
- **Sub-module `key_debounce`:** synchroniser plus debounce for one key, parameterised by DEBOUNCE_CYCLES/CNT_W. It outputs `st` and `chg`, and is instantiated three times.
- The top level holds the pending registers, arbiter and FSM.

## Test plan
Simulation uses DEBOUNCE_CYCLES = 4.
- **Single press:** hold draw_ready = 1; key_n = 3'b110 held for 10 cycles → key_down = 001 at cycle 6. One command issues: draw_key = 0, draw_on = 1, with draw_valid high for exactly 1 cycle. Release → draw_key = 0, draw_on = 0.
- **Glitch rejection:** key_n[1] low for 3 cycles, then high → key_down unchanged, no draw_valid.
- **Backpressure:** hold draw_ready = 0; press re → draw_valid = 1 with key 1, on 1, held stable for 20 cycles. Raise draw_ready → one handshake, then draw_valid = 0.
- **Round-robin:** hold draw_ready = 0; press all three keys simultaneously. Then set draw_ready = 1 → commands issue in order key 0, 1, 2, each with on = 1. No key is issued twice.
- **Overwrite:** hold draw_ready = 0 while mi is pressed and then released, both debounced. Then set draw_ready = 1 → exactly one mi command, with draw_on = 0.
- **Reset mid-issue:** while draw_valid = 1, assert resetn = 0 for 1 cycle → next cycle draw_valid = 0, key_down = 000, no further commands appear.

Source files
------------

// File: rtl/piano_pkg.sv
// Constants shared by the piano key front end and the square-drawing datapath.
package piano_pkg;

  localparam int unsigned NUM_KEYS = 3;

  localparam logic [1:0] KEY_DO = 2'd0;
  localparam logic [1:0] KEY_RE = 2'd1;
  localparam logic [1:0] KEY_MI = 2'd2;

  typedef enum logic {
    IDLE,
    ISSUE
  } draw_state_t;

  localparam logic [2:0] COLOUR_DO   = 3'b100;
  localparam logic [2:0] COLOUR_RE   = 3'b010;
  localparam logic [2:0] COLOUR_MI   = 3'b001;
  localparam logic [2:0] COLOUR_DARK = 3'b000;

  localparam logic [7:0] KEY_X_DO = 8'd0;
  localparam logic [7:0] KEY_X_RE = 8'd64;
  localparam logic [7:0] KEY_X_MI = 8'd128;
  localparam logic [6:0] KEY_Y    = 7'd87;

  // Index arithmetic modulo NUM_KEYS; callers pass at most 2*NUM_KEYS-1.
  function automatic logic [1:0] key_wrap(input logic [2:0] idx);
    return (idx >= 3'(NUM_KEYS)) ? 2'(idx - 3'(NUM_KEYS)) : idx[1:0];
  endfunction

  function automatic logic [2:0] key_colour(input logic [1:0] key, input logic on);
    logic [2:0] c;
    c = COLOUR_DARK;
    if (on) begin
      case (key)
        KEY_DO:  c = COLOUR_DO;
        KEY_RE:  c = COLOUR_RE;
        KEY_MI:  c = COLOUR_MI;
        default: c = COLOUR_DARK;
      endcase
    end
    return c;
  endfunction

  function automatic logic [7:0] key_x(input logic [1:0] key);
    logic [7:0] x;
    case (key)
      KEY_DO:  x = KEY_X_DO;
      KEY_RE:  x = KEY_X_RE;
      KEY_MI:  x = KEY_X_MI;
      default: x = KEY_X_DO;
    endcase
    return x;
  endfunction

endpackage

// File: rtl/piano_key_ctrl_debounce.sv
// Two-flop synchroniser plus counter debounce for one active-low key.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic st,
  output logic chg
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      st    <= 1'b1;
      cnt   <= '0;
      chg   <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      chg   <= 1'b0;
      if (sync2 == st) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        st  <= ~st;
        cnt <= '0;
        chg <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/piano_key_ctrl.sv
// Key front end: three debouncers, per-key pending commands, round-robin
// arbiter and a valid/ready draw-command issuer.
module piano_key_ctrl
  import piano_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] key_n,
  input  logic       draw_ready,
  output logic       draw_valid,
  output logic [1:0] draw_key,
  output logic       draw_on,
  output logic [2:0] key_down
);

  logic [NUM_KEYS-1:0] st;
  logic [NUM_KEYS-1:0] chg;
  logic [NUM_KEYS-1:0] pend;
  logic [NUM_KEYS-1:0] pend_on;
  logic [NUM_KEYS-1:0] req;
  logic [1:0]          ptr;
  logic [1:0]          sel;
  logic                sel_vld;
  logic                sel_on;
  logic                take;
  draw_state_t         state;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk   (clk),
      .resetn(resetn),
      .key_n (key_n[k]),
      .st    (st[k]),
      .chg   (chg[k])
    );
  end

  assign key_down = ~st;

  // A fresh chg pulse is arbitrated directly so an idle issuer answers in one
  // cycle; an already-pending key issues its stored level first.
  assign req = pend | chg;

  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (!sel_vld && req[key_wrap(3'(ptr) + 3'(i))]) begin
        sel     = key_wrap(3'(ptr) + 3'(i));
        sel_vld = 1'b1;
      end
    end
    sel_on = pend[sel] ? pend_on[sel] : ~st[sel];
    take   = (state == IDLE) && sel_vld;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      ptr        <= '0;
      pend       <= '0;
      pend_on    <= '0;
      draw_valid <= 1'b0;
      draw_key   <= '0;
      draw_on    <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        if (chg[k]) begin
          pend_on[k] <= ~st[k];
          // Consumed only when this very pulse is what gets issued now.
          pend[k]    <= !(take && sel == 2'(k) && !pend[k]);
        end else if (take && sel == 2'(k)) begin
          pend[k] <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (sel_vld) begin
            draw_key   <= sel;
            draw_on    <= sel_on;
            draw_valid <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (draw_ready) begin
            draw_valid <= 1'b0;
            ptr        <= key_wrap(3'(draw_key) + 3'd1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piano_key_ctrl.sv
// Directed and randomized bench for piano_key_ctrl with a short debounce window.
module tb_piano_key_ctrl;

  localparam int unsigned D = 4;

  logic       clk;
  logic       resetn;
  logic [2:0] key_n;
  logic       draw_ready;
  logic       draw_valid;
  logic [1:0] draw_key;
  logic       draw_on;
  logic [2:0] key_down;

  piano_key_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .key_n     (key_n),
    .draw_ready(draw_ready),
    .draw_valid(draw_valid),
    .draw_key  (draw_key),
    .draw_on   (draw_on),
    .key_down  (key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: key_n history (oldest first), debounced levels and run lengths.
  logic [2:0]  hist[$];
  logic [2:0]  model_kd;
  int unsigned run[3];
  logic        last_rep[3];

  logic [1:0]  log_key[$];
  logic        log_on[$];
  int          vcycles = 0;

  logic        last_valid = 1'b0;
  logic [1:0]  last_key   = '0;
  logic        last_on    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [2:0] synced;
    logic       pressed;
    if (!resetn) begin
      hist = '{3'b111, 3'b111};
      model_kd = '0;
      for (int k = 0; k < 3; k++) begin
        run[k] = 0;
        last_rep[k] = 1'b0;
      end
    end else begin
      synced = hist.pop_front();
      hist.push_back(key_n);
      for (int k = 0; k < 3; k++) begin
        pressed = !synced[k];
        if (pressed != model_kd[k]) begin
          run[k]++;
          if (run[k] == D) begin
            model_kd[k] = pressed;
            run[k] = 0;
          end
        end else begin
          run[k] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    logic hs;
    logic hold;
    hs   = resetn && last_valid && draw_ready;
    hold = resetn && last_valid && !draw_ready;
    @(posedge clk);
    model_step();
    if (hs) begin
      log_key.push_back(last_key);
      log_on.push_back(last_on);
      last_rep[last_key] = last_on;
    end
    @(negedge clk);
    if (hold) begin
      check("hold_valid", 32'(draw_valid), 1);
      check("hold_cmd", 32'({draw_key, draw_on}), 32'({last_key, last_on}));
    end
    check("key_down", 32'(key_down), 32'(model_kd));
    if (draw_valid) vcycles++;
    last_valid = draw_valid;
    last_key   = draw_key;
    last_on    = draw_on;
  endtask

  initial begin
    int n0;
    int v0;
    int hold_len;

    hist = '{3'b111, 3'b111};
    model_kd = '0;
    for (int k = 0; k < 3; k++) begin
      run[k] = 0;
      last_rep[k] = 1'b0;
    end

    resetn = 1'b0;
    key_n = 3'b111;
    draw_ready = 1'b1;
    repeat (3) tick();
    resetn = 1'b1;
    check("rst_valid", 32'(draw_valid), 0);
    check("rst_key", 32'(draw_key), 0);
    check("rst_on", 32'(draw_on), 0);
    check("rst_key_down", 32'(key_down), 0);

    // Single press of do with the consumer always ready.
    n0 = log_key.size();
    v0 = vcycles;
    key_n = 3'b110;
    repeat (5) tick();
    check("press_lat_early", 32'(key_down), 0);
    tick();
    check("press_lat", 32'(key_down), 32'h1);
    repeat (4) tick();
    check("press_cmds", 32'(log_key.size() - n0), 1);
    check("press_key", 32'(log_key[n0]), 0);
    check("press_on", 32'(log_on[n0]), 1);
    check("press_valid_len", 32'(vcycles - v0), 1);
    key_n = 3'b111;
    repeat (10) tick();
    check("release_cmds", 32'(log_key.size() - n0), 2);
    check("release_key", 32'(log_key[n0 + 1]), 0);
    check("release_on", 32'(log_on[n0 + 1]), 0);

    // Glitch on re shorter than the debounce window.
    n0 = log_key.size();
    v0 = vcycles;
    key_n = 3'b101;
    repeat (3) tick();
    key_n = 3'b111;
    repeat (10) tick();
    check("glitch_key_down", 32'(key_down), 0);
    check("glitch_cmds", 32'(log_key.size() - n0), 0);
    check("glitch_valid", 32'(vcycles - v0), 0);

    // Backpressure on a re press.
    draw_ready = 1'b0;
    key_n = 3'b101;
    repeat (10) tick();
    check("bp_valid", 32'(draw_valid), 1);
    check("bp_key", 32'(draw_key), 1);
    check("bp_on", 32'(draw_on), 1);
    repeat (20) tick();
    check("bp_valid_late", 32'(draw_valid), 1);
    check("bp_cmd_late", 32'({draw_key, draw_on}), 32'h3);
    n0 = log_key.size();
    draw_ready = 1'b1;
    tick();
    check("bp_drop", 32'(draw_valid), 0);
    check("bp_cmds", 32'(log_key.size() - n0), 1);
    check("bp_hs_cmd", 32'({log_key[n0], log_on[n0]}), 32'h3);
    key_n = 3'b111;
    repeat (10) tick();
    check("bp_release", 32'({log_key[n0 + 1], log_on[n0 + 1]}), 32'h2);

    // Round-robin from a fresh pointer.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    draw_ready = 1'b0;
    key_n = 3'b000;
    repeat (10) tick();
    check("rr_first_valid", 32'(draw_valid), 1);
    check("rr_first_key", 32'(draw_key), 0);
    n0 = log_key.size();
    draw_ready = 1'b1;
    repeat (8) tick();
    check("rr_cmds", 32'(log_key.size() - n0), 3);
    for (int i = 0; i < 3; i++) begin
      check("rr_order", 32'({log_key[n0 + i], log_on[n0 + i]}), 32'((i << 1) | 1));
    end
    key_n = 3'b111;
    repeat (16) tick();
    check("rr_rel_cmds", 32'(log_key.size() - n0), 6);
    for (int i = 0; i < 3; i++) begin
      check("rr_rel_order", 32'({log_key[n0 + 3 + i], log_on[n0 + 3 + i]}), 32'(i << 1));
    end

    // Overwrite: mi pressed and released while re is stuck in the handshake.
    draw_ready = 1'b0;
    key_n = 3'b101;
    repeat (10) tick();
    key_n = 3'b001;
    repeat (8) tick();
    key_n = 3'b101;
    repeat (8) tick();
    n0 = log_key.size();
    draw_ready = 1'b1;
    repeat (8) tick();
    check("ow_cmds", 32'(log_key.size() - n0), 2);
    check("ow_re", 32'({log_key[n0], log_on[n0]}), 32'h3);
    check("ow_mi", 32'({log_key[n0 + 1], log_on[n0 + 1]}), 32'h4);
    key_n = 3'b111;
    repeat (10) tick();

    // Reset while a command is waiting.
    draw_ready = 1'b0;
    key_n = 3'b110;
    repeat (10) tick();
    check("mid_valid", 32'(draw_valid), 1);
    n0 = log_key.size();
    resetn = 1'b0;
    key_n = 3'b111;
    tick();
    check("mid_rst_valid", 32'(draw_valid), 0);
    check("mid_rst_key_down", 32'(key_down), 0);
    resetn = 1'b1;
    v0 = vcycles;
    repeat (15) tick();
    check("mid_no_valid", 32'(vcycles - v0), 0);
    check("mid_no_cmds", 32'(log_key.size() - n0), 0);

    // Randomized key traffic and backpressure.
    for (int it = 0; it < 80; it++) begin
      key_n = 3'($urandom_range(0, 7));
      draw_ready = 1'($urandom_range(0, 1));
      hold_len = $urandom_range(1, 10);
      repeat (hold_len) begin
        tick();
        if ($urandom_range(0, 3) == 0) draw_ready = !draw_ready;
      end
    end
    draw_ready = 1'b1;
    repeat (24) tick();
    check("rand_idle", 32'(draw_valid), 0);
    for (int k = 0; k < 3; k++) begin
      check("rand_final_level", 32'(last_rep[k]), 32'(model_kd[k]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
